// File: rtl/music_pkg.sv
// Shared definitions for the song sequencer: field widths, ROM word
// layout helpers and the sequencer state encoding.
package music_pkg;

    localparam int SONG_W = 2;               // 4 songs
    localparam int IDX_W  = 5;               // 32 entries per song
    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int ROM_W  = NOTE_W + DUR_W;  // ROM word {note, duration}
    localparam int ADDR_W = SONG_W + IDX_W;  // ROM address {song, idx}

    localparam logic [NOTE_W-1:0] REST_NOTE = '0;
    localparam logic [DUR_W-1:0]  END_DUR   = '0;   // duration 0 ends a song

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        PLAYING,
        DONE
    } state_t;

    // Note code held in the upper field of a ROM word.
    function automatic logic [NOTE_W-1:0] word_note(input logic [ROM_W-1:0] w);
        return w[ROM_W-1:DUR_W];
    endfunction

    // Duration held in the lower field of a ROM word.
    function automatic logic [DUR_W-1:0] word_dur(input logic [ROM_W-1:0] w);
        return w[DUR_W-1:0];
    endfunction

endpackage

// File: rtl/song_reader.sv
// song_reader: walks one 32-entry song of the song ROM and hands each
// {note, duration} to the note player.
// Optional build macro: SONG_READER_LOOP_EN -- when defined, a finished
// song restarts from entry 0 while play stays high instead of idling.
//
// Player handshake: new_note is a one-cycle strobe meaning note/duration
// now hold a fresh entry and stay stable until the next strobe or the
// end of the song. The player answers with a one-cycle note_done pulse
// once that note has finished; note_done only counts while the reader
// is PLAYING with play high, and is dropped in every other case.
// The ROM has one cycle of registered read latency: rom_addr is held
// through FETCH and the matching rom_dout is consumed in CAPTURE.
// The current FSM state is the register `state`, for checker binding.
module song_reader
    import music_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic [SONG_W-1:0] song,
    input  logic              note_done,
    input  logic [ROM_W-1:0]  rom_dout,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [NOTE_W-1:0] note,
    output logic [DUR_W-1:0]  duration,
    output logic              new_note,
    output logic              song_done,
    output logic              busy
);

    state_t            state;
    logic [SONG_W-1:0] song_q;
    logic [IDX_W-1:0]  idx;
    logic              song_change;
    logic              restart;
    logic              last_idx;

    // A different song selected mid-walk restarts from its first entry;
    // DONE finishes its pulse first and IDLE latches the song anyway.
    assign song_change = (song != song_q);
    assign restart     = song_change &&
                         (state == FETCH || state == CAPTURE || state == PLAYING);
    assign last_idx    = &idx;

    // Sequencer FSM, index counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            song_q    <= '0;
            idx       <= '0;
            rom_addr  <= '0;
            note      <= '0;
            duration  <= '0;
            new_note  <= 1'b0;
            song_done <= 1'b0;
            busy      <= 1'b0;
        end else begin
            new_note  <= 1'b0;
            song_done <= 1'b0;
            if (restart) begin
                // Song change wins over a simultaneous note_done.
                song_q   <= song;
                idx      <= '0;
                rom_addr <= {song, {IDX_W{1'b0}}};
                state    <= FETCH;
            end else begin
                case (state)
                    IDLE: begin
                        if (play) begin
                            song_q   <= song;
                            idx      <= '0;
                            rom_addr <= {song, {IDX_W{1'b0}}};
                            busy     <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                    FETCH: begin
                        state <= CAPTURE;
                    end
                    CAPTURE: begin
                        if (word_dur(rom_dout) == END_DUR) begin
                            song_done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            note     <= word_note(rom_dout);
                            duration <= word_dur(rom_dout);
                            new_note <= 1'b1;
                            state    <= PLAYING;
                        end
                    end
                    PLAYING: begin
                        if (play && note_done) begin
                            if (last_idx) begin
                                // Entry 31 was the last one; never wrap to 0.
                                song_done <= 1'b1;
                                state     <= DONE;
                            end else begin
                                idx      <= idx + 1'b1;
                                rom_addr <= {song_q, idx + 1'b1};
                                state    <= FETCH;
                            end
                        end
                    end
                    DONE: begin
                        note     <= REST_NOTE;
                        duration <= END_DUR;
`ifdef SONG_READER_LOOP_EN
                        if (play) begin
                            idx      <= '0;
                            rom_addr <= {song_q, {IDX_W{1'b0}}};
                            state    <= FETCH;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
`else
                        busy  <= 1'b0;
                        state <= IDLE;
`endif
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: a behavioural song ROM, a first-strobe vector
// table, randomized full-song walks checked against an expected-entry
// queue built from the ROM contents, and hand-written corner sequences.
module tb_song_reader;
    import music_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              play;
    logic [SONG_W-1:0] song;
    logic              note_done;
    logic [ROM_W-1:0]  rom_dout = '0;
    logic [ADDR_W-1:0] rom_addr;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  duration;
    logic              new_note;
    logic              song_done;
    logic              busy;

    logic [ROM_W-1:0]  rom [128];
    logic [ROM_W-1:0]  exp_q[$];
    int                n_tests = 0;
    int                n_fail  = 0;

    typedef struct {
        logic [1:0] song;
        logic [5:0] note;
        logic [5:0] dur;
        logic [6:0] addr;
    } vec_t;
    vec_t vecs[4];

    // clock / reset block
    always #5 clk = ~clk;

    // Song ROM with one cycle of registered read latency.
    always @(posedge clk) rom_dout <= rom[rom_addr];

    song_reader dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .song      (song),
        .note_done (note_done),
        .rom_dout  (rom_dout),
        .rom_addr  (rom_addr),
        .note      (note),
        .duration  (duration),
        .new_note  (new_note),
        .song_done (song_done),
        .busy      (busy)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic init_rom();
        for (int a = 0; a < 128; a++)
            rom[a] = {6'($urandom_range(0, 63)), 6'($urandom_range(1, 63))};
        rom[0]   = {6'd49, 6'd12};
        rom[1]   = {6'd1,  6'd8};
        rom[28]  = {6'd37, 6'd0};   // song 0 ends by marker at entry 28
        rom[32]  = {6'd35, 6'd36};
        rom[40]  = {6'd0,  6'd20};  // rest inside song 1
        rom[64]  = {6'd43, 6'd6};
        rom[66]  = {6'd0,  6'd34};  // rest inside song 2
        rom[80]  = {6'd0,  6'd0};   // song 2 ends by marker at entry 16
        rom[96]  = {6'd17, 6'd3};
        rom[127] = {6'd0,  6'd0};   // song 3 ends by marker at entry 31
    endtask

    task automatic do_reset();
        reset = 1'b1; play = 1'b0; note_done = 1'b0; song = '0;
        step();
        step();
        reset = 1'b0;
        check("reset_outputs", {rom_addr, note, duration, new_note, song_done, busy}, 0);
    endtask

    // Steps until a strobe or song_done shows up, bounded by 12 cycles.
    // Any note_done driven before the call is a single-cycle pulse.
    task automatic wait_event(output int steps, output bit got_note, output bit got_done);
        steps = 0; got_note = 1'b0; got_done = 1'b0;
        while (steps < 12 && !got_note && !got_done) begin
            step();
            steps++;
            note_done = 1'b0;
            got_note = new_note;
            got_done = song_done;
        end
    endtask

    // Plays a whole song with random player delays and pauses; the
    // expected entries come straight from the ROM contents.
    task automatic run_song(input logic [1:0] s);
        int steps;
        bit gn, gd, marker;
        logic [ROM_W-1:0] w, exp;
        exp_q.delete();
        marker = 1'b0;
        for (int i = 0; i < 32; i++) begin
            w = rom[s * 32 + i];
            if (w[5:0] == 6'd0) begin
                marker = 1'b1;
                break;
            end
            exp_q.push_back(w);
        end
        song = s;
        play = 1'b1;
        for (int i = 0; exp_q.size() > 0; i++) begin
            wait_event(steps, gn, gd);
            check("strobe_seen", gn, 1);
            if (!gn) return;
            check("strobe_latency", steps, 3);
            exp = exp_q.pop_front();
            check("note", note, exp[11:6]);
            check("duration", duration, exp[5:0]);
            check("rom_addr", rom_addr, s * 32 + i);
            repeat ($urandom_range(0, 3)) begin
                step();
                check("no_extra_strobe", new_note, 0);
            end
            if ($urandom_range(0, 3) == 0) begin
                play = 1'b0;
                repeat (3) begin
                    note_done = 1'b1;
                    step();
                    note_done = 1'b0;
                    step();
                    check("pause_hold", {busy, new_note, song_done}, 3'b100);
                end
                play = 1'b1;
            end
            note_done = 1'b1;
        end
        wait_event(steps, gn, gd);
        check("song_done_seen", gd, 1);
        check("song_done_latency", steps, marker ? 3 : 1);
        check("no_strobe_on_end", gn, 0);
        play = 1'b0;
        step();
        check("busy_after_done", busy, 0);
        check("note_cleared", {note, duration}, 0);
    endtask

    initial begin
        int steps;
        bit gn, gd;

        vecs[0] = '{2'd0, 6'd49, 6'd12, 7'd0};
        vecs[1] = '{2'd1, 6'd35, 6'd36, 7'd32};
        vecs[2] = '{2'd2, 6'd43, 6'd6,  7'd64};
        vecs[3] = '{2'd3, 6'd17, 6'd3,  7'd96};

        init_rom();
        do_reset();

        // first strobe of each song from a fresh reset
        for (int v = 0; v < 4; v++) begin
            song = vecs[v].song;
            play = 1'b1;
            wait_event(steps, gn, gd);
            check("vec_strobe", gn, 1);
            check("vec_latency", steps, 3);
            check("vec_note", note, vecs[v].note);
            check("vec_dur", duration, vecs[v].dur);
            check("vec_addr", rom_addr, vecs[v].addr);
            check("vec_busy", busy, 1);
            do_reset();
        end

        // full songs: each song once, then a few random picks
        for (int s = 0; s < 4; s++) run_song(2'(s));
        repeat (3) run_song(2'($urandom_range(0, 3)));

        // pause with note_done ignored, then song change 1->2 with note_done
        do_reset();
        song = 2'd1; play = 1'b1;
        wait_event(steps, gn, gd);
        check("sc_first_note", note, 35);
        note_done = 1'b1;
        wait_event(steps, gn, gd);
        check("sc_second_note", {note, duration}, rom[33]);
        play = 1'b0;
        for (int c = 0; c < 20; c++) begin
            note_done = c[0];
            step();
            check("pause20_strobe", new_note, 0);
        end
        note_done = 1'b0;
        check("pause20_addr", rom_addr, 33);
        check("pause20_busy", busy, 1);
        play = 1'b1;
        song = 2'd2;
        note_done = 1'b1;
        wait_event(steps, gn, gd);
        check("sc_strobe", gn, 1);
        check("sc_no_done", gd, 0);
        check("sc_latency", steps, 3);
        check("sc_addr", rom_addr, 64);
        check("sc_note", note, 43);
        check("sc_dur", duration, 6);

        // reset while a note is playing
        reset = 1'b1;
        step();
        check("midnote_reset", {rom_addr, note, duration, new_note, song_done, busy}, 0);
        reset = 1'b0; play = 1'b0;
        step();
        check("midnote_idle", busy, 0);

`ifdef SONG_READER_LOOP_EN
        // keep play high through the end: the same song starts again
        song = 2'd2; play = 1'b1;
        gd = 1'b0;
        for (int k = 0; k < 40 && !gd; k++) begin
            wait_event(steps, gn, gd);
            if (gn) note_done = 1'b1;
        end
        check("loop_done_seen", gd, 1);
        wait_event(steps, gn, gd);
        check("loop_restrobe", gn, 1);
        check("loop_latency", steps, 3);
        check("loop_note", {note, duration}, {6'd43, 6'd6});
        check("loop_addr", rom_addr, 64);
        do_reset();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
